fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of decode and drives the read side of memory_32bit. It holds the PC, issues single-word reads, and captures the returned word. It presents the instruction to decode under a valid/stall handshake and supports branch redirect. It flags out-of-range, misaligned or timed-out fetches as a sticky fault.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, memory access encodings
// and the fetch/load-store address window check.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    localparam logic [1:0] ACCESS_1WORD = 2'd0;
    localparam logic [1:0] ACCESS_4WORD = 2'd1;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int MEM_BYTES_DEFAULT = 1048576;

    // Word-aligned and inside [base, base+bytes-4]; 33-bit math so the top bound cannot wrap.
    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] bytes
    );
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] a;
        lo = {1'b0, base};
        hi = lo + bytes - 33'd4;
        a  = {1'b0, addr};
        return (addr[1:0] == 2'b00) && (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, issues single-word reads to memory_32bit
// and presents the returned word to decode under a valid/stall handshake.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int          MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int          MAX_WAIT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_enable,
    output logic        mem_read_write,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out,
    input  logic        mem_busy,
    output logic        insn_valid,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int              WCW       = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MAX_WAIT - 1);
    localparam logic [32:0]     WIN_BYTES = 33'(MEM_BYTES);

    fetch_state_t   r_state;
    logic [31:0]    r_pc;
    logic           r_mem_enable;
    logic [31:0]    r_mem_address;
    logic           r_insn_valid;
    logic [31:0]    r_insn;
    logic [31:0]    r_insn_pc;
    logic           r_fault;
    logic [31:0]    r_fault_pc;
    logic [WCW-1:0] r_wait_cnt;

    fetch_state_t   w_state_nxt;
    logic           w_go_check;
    logic [31:0]    w_check_pc;
    logic           w_legal;
    logic           w_capture;
    logic [31:0]    w_pc_nxt;
    logic           w_mem_enable_nxt;
    logic [31:0]    w_mem_address_nxt;
    logic           w_insn_valid_nxt;
    logic [31:0]    w_insn_nxt;
    logic [31:0]    w_insn_pc_nxt;
    logic           w_fault_nxt;
    logic [31:0]    w_fault_pc_nxt;
    logic [WCW-1:0] w_wait_cnt_nxt;

    // Pick the PC that must pass the window check before the next ISSUE.
    always_comb begin
        w_go_check = 1'b0;
        w_check_pc = r_pc;
        if (redirect) begin
            w_go_check = 1'b1;
            w_check_pc = redirect_pc;
        end else if (r_state == IDLE) begin
            w_go_check = 1'b1;
            w_check_pc = r_pc;
        end else if ((r_state == HOLD) && !stall) begin
            w_go_check = 1'b1;
            w_check_pc = r_pc + 32'd4;
        end else begin
            w_go_check = 1'b0;
            w_check_pc = r_pc;
        end
    end

    assign w_legal = addr_in_window(w_check_pc, MEM_BASE, WIN_BYTES);

    // Next-state logic; redirect is folded in through w_go_check.
    always_comb begin
        w_state_nxt = r_state;
        if (w_go_check) begin
            w_state_nxt = w_legal ? ISSUE : FAULT;
        end else begin
            case (r_state)
                ISSUE: w_state_nxt = WAIT;
                WAIT: begin
                    if (!mem_busy) begin
                        w_state_nxt = HOLD;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        w_state_nxt = FAULT;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
                HOLD:    w_state_nxt = HOLD;
                FAULT:   w_state_nxt = FAULT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, decoded from the state being entered.
    always_comb begin
        w_capture         = (r_state == WAIT) && !mem_busy && !redirect;
        w_pc_nxt          = w_go_check ? w_check_pc : r_pc;
        w_mem_enable_nxt  = (w_state_nxt == ISSUE);
        w_mem_address_nxt = (w_state_nxt == ISSUE) ? w_check_pc : r_mem_address;
        w_insn_valid_nxt  = (w_state_nxt == HOLD);
        w_fault_nxt       = (w_state_nxt == FAULT);
        if (w_capture) begin
            w_insn_nxt    = mem_data_out;
            w_insn_pc_nxt = r_pc;
        end else begin
            w_insn_nxt    = r_insn;
            w_insn_pc_nxt = r_insn_pc;
        end
        // A fresh fault (bad target or timeout) latches the offending PC.
        if ((w_state_nxt == FAULT) && (w_go_check || (r_state != FAULT))) begin
            w_fault_pc_nxt = w_check_pc;
        end else begin
            w_fault_pc_nxt = r_fault_pc;
        end
        if ((r_state == WAIT) && mem_busy && !redirect) begin
            w_wait_cnt_nxt = r_wait_cnt + {{(WCW-1){1'b0}}, 1'b1};
        end else begin
            w_wait_cnt_nxt = {WCW{1'b0}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= PC_RESET;
            r_mem_enable  <= 1'b0;
            r_mem_address <= 32'd0;
            r_insn_valid  <= 1'b0;
            r_insn        <= 32'd0;
            r_insn_pc     <= 32'd0;
            r_fault       <= 1'b0;
            r_fault_pc    <= 32'd0;
            r_wait_cnt    <= {WCW{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_mem_enable  <= w_mem_enable_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_insn_valid  <= w_insn_valid_nxt;
            r_insn        <= w_insn_nxt;
            r_insn_pc     <= w_insn_pc_nxt;
            r_fault       <= w_fault_nxt;
            r_fault_pc    <= w_fault_pc_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    assign mem_enable      = r_mem_enable;
    assign mem_read_write  = RW_READ;
    assign mem_address     = r_mem_address;
    assign mem_access_size = ACCESS_1WORD;
    assign insn_valid      = r_insn_valid;
    assign insn            = r_insn;
    assign insn_pc         = r_insn_pc;
    assign fault           = r_fault;
    assign fault_pc        = r_fault_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// phase checked against a handshake-level PC/instruction model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_enable;
    logic        mem_read_write;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_out = 32'd0;
    logic        mem_busy = 1'b0;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        fault;
    logic [31:0] fault_pc;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_enable(mem_enable),
        .mem_read_write(mem_read_write), .mem_address(mem_address),
        .mem_access_size(mem_access_size), .mem_data_out(mem_data_out),
        .mem_busy(mem_busy), .insn_valid(insn_valid), .insn(insn),
        .insn_pc(insn_pc), .fault(fault), .fault_pc(fault_pc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Backing store for the 1 MiB window.
    logic [31:0] mem_arr [0:262143];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem_arr[a[19:2]];
    endfunction

    function automatic logic legal_pc(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (ua % 4 == 0) && (ua <= 1048576 - 4);
    endfunction

    // Memory model: a request gets a random number of busy cycles, garbage while busy.
    int          lat_max    = 0;
    int          busy_cnt   = 0;
    logic        force_busy = 1'b0;
    logic [31:0] req_addr   = 32'd0;

    always @(negedge clk) begin : mem_model
        logic b;
        int   l;
        if (mem_enable) begin
            l = (lat_max > 0) ? int'($urandom_range(lat_max, 0)) : 0;
            busy_cnt <= l;
            req_addr <= mem_address;
            b = force_busy;
            mem_busy     <= b;
            mem_data_out <= $urandom;
        end else begin
            b = force_busy || (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            mem_busy     <= b;
            mem_data_out <= b ? $urandom : word_at(req_addr);
        end
    end

    // Reference model: which PC decode should see next, from handshake rules only.
    logic [31:0] exp_pc = 32'd0;
    int          cyc    = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset)                      exp_pc <= 32'd0;
        else if (redirect)              exp_pc <= redirect_pc;
        else if (insn_valid && !stall)  exp_pc <= exp_pc + 32'd4;
    end

    logic        prev_valid = 1'b0;
    logic        prev_fault = 1'b0;
    logic [31:0] prev_insn  = 32'd0;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
            prev_fault <= 1'b0;
        end else begin
            check_val("rw_const", 32'(mem_read_write), 32'd1);
            check_val("size_const", 32'(mem_access_size), 32'd0);
            if (insn_valid && !prev_valid) begin
                check_val("mon_insn_pc", insn_pc, exp_pc);
                check_val("mon_insn", insn, word_at(exp_pc));
            end
            if (insn_valid && prev_valid) check_val("mon_hold_insn", insn, prev_insn);
            if (mem_enable) begin
                check_val("mon_mem_addr", mem_address, exp_pc);
                check_val("mon_addr_legal", 32'(legal_pc(mem_address)), 32'd1);
            end
            if (fault && !prev_fault) check_val("mon_fault_pc", fault_pc, exp_pc);
            prev_valid <= insn_valid;
            prev_fault <= fault;
            prev_insn  <= insn;
        end
    end

    task automatic wait_present(input string tag);
        int n = 0;
        @(negedge clk);
        while (!insn_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!insn_valid) check_val({tag, "_present_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_mem_en(input string tag);
        int n = 0;
        @(negedge clk);
        while (!mem_enable && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!mem_enable) check_val({tag, "_mem_en_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mem_enable"}, 32'(mem_enable), 32'd0);
        check_val({tag, "_mem_address"}, mem_address, 32'd0);
        check_val({tag, "_insn_valid"}, 32'(insn_valid), 32'd0);
        check_val({tag, "_insn"}, insn, 32'd0);
        check_val({tag, "_insn_pc"}, insn_pc, 32'd0);
        check_val({tag, "_fault"}, 32'(fault), 32'd0);
        check_val({tag, "_fault_pc"}, fault_pc, 32'd0);
        check_val({tag, "_rw"}, 32'(mem_read_write), 32'd1);
        check_val({tag, "_size"}, 32'(mem_access_size), 32'd0);
    endtask

    logic [31:0] tbl [0:3];

    initial begin
        int t_prev;
        int en_seen;
        int r;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        for (int i = 0; i < 262144; i++) mem_arr[i] = (i * 32'h9E37_79B9) ^ 32'h5A5A_1234;
        tbl[0] = 32'd234; tbl[1] = 32'd1537628013; tbl[2] = 32'd537628013; tbl[3] = 32'd2537628013;
        for (int i = 0; i < 4; i++) mem_arr[i] = tbl[i];

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Back-to-back fetches, zero latency: one instruction every 3 cycles.
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_present("seq");
            check_val("seq_insn", insn, tbl[i]);
            check_val("seq_insn_pc", insn_pc, 32'(4 * i));
            if (i > 0) check_val("seq_spacing", 32'(cyc - t_prev), 32'd3);
            t_prev = cyc;
        end

        // Stall while holding pc=4.
        @(negedge clk);
        do_redirect(32'd4);
        wait_present("stall");
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("stall_valid", 32'(insn_valid), 32'd1);
            check_val("stall_insn", insn, tbl[1]);
            check_val("stall_insn_pc", insn_pc, 32'd4);
            check_val("stall_no_req", 32'(mem_enable), 32'd0);
        end
        stall = 1'b0;
        wait_mem_en("stall_next");
        check_val("stall_next_addr", mem_address, 32'd8);

        // Redirect while the pc=4 read is outstanding.
        lat_max = 4;
        @(negedge clk);
        do_redirect(32'd0);
        wait_present("rdw0");
        check_val("rdw0_insn", insn, tbl[0]);
        wait_mem_en("rdw_req4");
        check_val("rdw_req4_addr", mem_address, 32'd4);
        @(negedge clk);
        do_redirect(32'd12);
        wait_present("rdw12");
        check_val("rdw_insn_pc", insn_pc, 32'd12);
        check_val("rdw_insn", insn, tbl[3]);

        // Last word of the window, then running off the end.
        @(negedge clk);
        do_redirect(32'd1048572);
        wait_present("top");
        check_val("top_insn_pc", insn_pc, 32'd1048572);
        check_val("top_insn", insn, word_at(32'd1048572));
        en_seen = 0;
        for (int k = 0; k < 10 && !fault; k++) begin
            @(negedge clk);
            if (mem_enable) en_seen++;
        end
        check_val("top_fault", 32'(fault), 32'd1);
        check_val("top_fault_pc", fault_pc, 32'd1048576);
        check_val("top_no_req", 32'(en_seen), 32'd0);

        // Misaligned target faults on the redirect edge; redirect to 0 recovers.
        do_redirect(32'd6);
        check_val("mis_fault", 32'(fault), 32'd1);
        check_val("mis_fault_pc", fault_pc, 32'd6);
        check_val("mis_valid", 32'(insn_valid), 32'd0);
        check_val("mis_no_req", 32'(mem_enable), 32'd0);
        do_redirect(32'd0);
        check_val("mis_clear", 32'(fault), 32'd0);
        wait_present("mis_resume");
        check_val("mis_resume_insn", insn, tbl[0]);

        // Memory stuck busy: fault after 15 busy cycles in WAIT.
        lat_max = 0;
        @(negedge clk);
        force_busy = 1'b1;
        do_redirect(32'd8);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 15) check_val("tmo_before", 32'(fault), 32'd0);
            if (k == 16) begin
                check_val("tmo_fault", 32'(fault), 32'd1);
                check_val("tmo_fault_pc", fault_pc, 32'd8);
            end
            if (k == 20) check_val("tmo_sticky", 32'(fault), 32'd1);
        end

        // Reset while a read is in flight.
        do_redirect(32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        force_busy = 1'b0;
        wait_present("midrst_resume");
        check_val("midrst_insn", insn, tbl[0]);
        check_val("midrst_insn_pc", insn_pc, 32'd0);

        // Randomized traffic checked by the monitor and reference model.
        lat_max = 3;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            stall    = ($urandom_range(99, 0) < 30);
            redirect = ($urandom_range(99, 0) < 4);
            r = int'($urandom_range(99, 0));
            if (r < 70)      redirect_pc = {12'd0, 18'($urandom_range(262143, 0)), 2'b00};
            else if (r < 85) redirect_pc = 32'(4 * $urandom_range(15, 0));
            else if (r < 93) redirect_pc = (r < 89) ? 32'd1048572 : 32'd1048576;
            else             redirect_pc = $urandom;
        end
        @(negedge clk);
        stall = 1'b0;
        redirect = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
